// File: rtl/video_path_sel_pkg.sv
// Shared definitions for the video path select slice.
//   vsel_state_t : output FSM states (RUN passes the source, WAIT blanks it)
//   VID_DATA_W   : default pixel width (RGB565)
//   VID_CNT_W    : width of the window position counters
//   rise()       : rising-edge detect from current and previous sample
package video_path_sel_pkg;

    localparam int VID_DATA_W = 16;
    localparam int VID_CNT_W  = 12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } vsel_state_t;

    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/video_path_sel_vid_window.sv
// Crops a raw pixel stream to an H_ACT x V_ACT window at (H_START, V_START).
// Ports:
//   pixel_clk, rst_n          clock, asynchronous active-low reset
//   pdata_i, de_i, vs_i       raw pixel, data enable, vsync (rising = frame start)
//   win_data_o, win_de_o      cropped pixel (0 outside window) and enable, 1-cycle latency
//   win_vs_o                  vsync delayed to match
module vid_window
    import video_path_sel_pkg::*;
#(
    parameter int DATA_W  = VID_DATA_W,
    parameter int H_START = 80,
    parameter int H_ACT   = 320,
    parameter int V_START = 0,
    parameter int V_ACT   = 480
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pdata_i,
    input  logic              de_i,
    input  logic              vs_i,
    output logic [DATA_W-1:0] win_data_o,
    output logic              win_de_o,
    output logic              win_vs_o
);

    logic [VID_CNT_W-1:0] x_cnt;
    logic [VID_CNT_W-1:0] y_cnt;
    logic                 de_d;
    logic                 vs_d;
    logic                 in_win;

    // x_cnt holds the index of the current pixel within the line
    always_comb begin
        in_win = de_i
              && (int'(x_cnt) >= H_START) && (int'(x_cnt) < H_START + H_ACT)
              && (int'(y_cnt) >= V_START) && (int'(y_cnt) < V_START + V_ACT);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            de_d       <= 1'b0;
            vs_d       <= 1'b0;
            win_data_o <= '0;
            win_de_o   <= 1'b0;
            win_vs_o   <= 1'b0;
        end else begin
            de_d <= de_i;
            vs_d <= vs_i;

            if (!de_i)
                x_cnt <= '0;
            else if (x_cnt != '1)
                x_cnt <= x_cnt + 1'b1;

            if (rise(vs_i, vs_d))
                y_cnt <= '0;
            else if (rise(de_d, de_i) && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;

            win_de_o   <= in_win;
            win_data_o <= in_win ? pdata_i : '0;
            win_vs_o   <= vs_i;
        end
    end

endmodule

// File: rtl/video_path_sel.sv
// Camera chain front/back end.
//   Front end: vid_window crops the raw stream for the processing chains.
//   Back end : selects one of NUM_SRC returned streams, switching only on a frame
//              edge of the active source, blanking BLANK_FR frames after a switch.
//              Reports an output frame count and a sticky line-length error.
// Ports:
//   pixel_clk, rst_n                        clock, asynchronous active-low reset
//   pdata_i, de_i, vs_i                     raw camera stream
//   mode_i                                  asynchronous source select
//   win_data_o, win_de_o, win_vs_o          cropped stream to chains
//   src_data_i, src_de_i, src_vs_i          returned chain streams (source k at slot k)
//   pdata_o, de_o, vs_o                     selected stream, 1-cycle latency
//   mode_o                                  active source index
//   frame_cnt_o, line_err_o                 frame counter, sticky line-length error
module video_path_sel
    import video_path_sel_pkg::*;
#(
    parameter int DATA_W   = VID_DATA_W,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int H_START  = 80,
    parameter int H_ACT    = 320,
    parameter int V_START  = 0,
    parameter int V_ACT    = 480,
    parameter int BLANK_FR = 1
) (
    input  logic                      pixel_clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         pdata_i,
    input  logic                      de_i,
    input  logic                      vs_i,
    input  logic [SEL_W-1:0]          mode_i,
    output logic [DATA_W-1:0]         win_data_o,
    output logic                      win_de_o,
    output logic                      win_vs_o,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]        src_de_i,
    input  logic [NUM_SRC-1:0]        src_vs_i,
    output logic [DATA_W-1:0]         pdata_o,
    output logic                      de_o,
    output logic                      vs_o,
    output logic [SEL_W-1:0]          mode_o,
    output logic [15:0]               frame_cnt_o,
    output logic                      line_err_o
);

    localparam int BW = $clog2(BLANK_FR + 1);

    vid_window #(
        .DATA_W  (DATA_W),
        .H_START (H_START),
        .H_ACT   (H_ACT),
        .V_START (V_START),
        .V_ACT   (V_ACT)
    ) u_window (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .pdata_i    (pdata_i),
        .de_i       (de_i),
        .vs_i       (vs_i),
        .win_data_o (win_data_o),
        .win_de_o   (win_de_o),
        .win_vs_o   (win_vs_o)
    );

    vsel_state_t          state, state_nxt;
    logic [SEL_W-1:0]     mode_m1, mode_m2, pending, active, active_nxt;
    logic [BW-1:0]        blank_cnt, blank_nxt;
    logic [NUM_SRC-1:0]   src_vs_d;
    logic                 sel_vs, sel_vs_prev, sel_de, frame_edge, switch_now;
    logic [DATA_W-1:0]    sel_data;
    logic                 vs_o_d, de_o_d;
    logic [VID_CNT_W-1:0] line_cnt;

    // Per-source history keeps the edge detect valid right after active changes
    always_comb begin
        sel_vs      = 1'b0;
        sel_vs_prev = 1'b0;
        sel_de      = 1'b0;
        sel_data    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (active == SEL_W'(k)) begin
                sel_vs      = src_vs_i[k];
                sel_vs_prev = src_vs_d[k];
                sel_de      = src_de_i[k];
                sel_data    = src_data_i[k*DATA_W +: DATA_W];
            end
        end
        frame_edge = rise(sel_vs, sel_vs_prev);
    end

    always_comb begin
        state_nxt  = state;
        active_nxt = active;
        blank_nxt  = blank_cnt;
        switch_now = 1'b0;
        if (frame_edge) begin
            if (pending != active) begin
                active_nxt = pending;
                state_nxt  = ST_WAIT;
                blank_nxt  = '0;
                switch_now = 1'b1;
            end else if (state == ST_WAIT) begin
                blank_nxt = blank_cnt + 1'b1;
                // Enter RUN on the edge itself so the frame starting here is whole
                if (int'(blank_nxt) >= BLANK_FR)
                    state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            active    <= '0;
            pending   <= '0;
            mode_m1   <= '0;
            mode_m2   <= '0;
            blank_cnt <= '0;
            src_vs_d  <= '0;
        end else begin
            mode_m1   <= mode_i;
            mode_m2   <= mode_m1;
            if (int'(mode_m2) < NUM_SRC)
                pending <= mode_m2;
            state     <= state_nxt;
            active    <= active_nxt;
            blank_cnt <= blank_nxt;
            src_vs_d  <= src_vs_i;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            pdata_o     <= '0;
            de_o        <= 1'b0;
            vs_o        <= 1'b0;
            vs_o_d      <= 1'b0;
            de_o_d      <= 1'b0;
            frame_cnt_o <= '0;
            line_err_o  <= 1'b0;
            line_cnt    <= '0;
        end else begin
            de_o    <= (state_nxt == ST_RUN) && sel_de;
            pdata_o <= ((state_nxt == ST_RUN) && sel_de) ? sel_data : '0;
            vs_o    <= sel_vs;
            vs_o_d  <= vs_o;
            de_o_d  <= de_o;

            if (state == ST_RUN && rise(vs_o, vs_o_d))
                frame_cnt_o <= frame_cnt_o + 1'b1;

            if (rise(de_o_d, de_o)) begin
                if (state == ST_RUN && int'(line_cnt) != H_ACT)
                    line_err_o <= 1'b1;
                line_cnt <= '0;
            end else if (state == ST_RUN && de_o && line_cnt != '1) begin
                line_cnt <= line_cnt + 1'b1;
            end

            if (switch_now) begin
                line_err_o <= 1'b0;
                line_cnt   <= '0;
            end
        end
    end

    assign mode_o = active;

endmodule
